// File: rtl/i2c_master_arbiter_if.sv
// Bundle of requester-side and i2c_master-side signals for the arbiter.
// Port summary: req_* / rsp_* face the NUM_REQ requesters, m_* face one i2c_master.
// Modport master = arbiter view, modport slave = environment (requesters + i2c_master).
interface i2c_master_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [7*NUM_REQ-1:0]  req_chip_addr;
  logic [8*NUM_REQ-1:0]  req_reg_addr;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    rsp_done;
  logic [15:0]           rsp_data;
  logic [4:0]            rsp_status;
  logic                  rsp_nostart;
  // i2c_master command port
  logic [6:0]            m_chip_addr;
  logic [7:0]            m_reg_addr;
  logic [15:0]           m_datai;
  logic                  m_we;
  logic                  m_re;
  logic                  m_busy;
  logic [4:0]            m_status;
  logic [15:0]           m_datao;

  modport master (
    input  req_valid, req_we, req_chip_addr, req_reg_addr, req_data,
    input  m_busy, m_status, m_datao,
    output req_ack, rsp_done, rsp_data, rsp_status, rsp_nostart,
    output m_chip_addr, m_reg_addr, m_datai, m_we, m_re
  );

  modport slave (
    output req_valid, req_we, req_chip_addr, req_reg_addr, req_data,
    output m_busy, m_status, m_datao,
    input  req_ack, rsp_done, rsp_data, rsp_status, rsp_nostart,
    input  m_chip_addr, m_reg_addr, m_datai, m_we, m_re
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master command port among NUM_REQ requesters.
// Latency: req_ack + strobe 1 cycle after grant; rsp_done 1 cycle after master busy is seen low
//   (START_WAIT+2 cycles after req_ack if busy never rises); all outputs registered.
// Backpressure: requesters hold req_valid until req_ack; no grant while a transaction is
//   in flight or while m_busy is high.
// Ports: clk, reset_n (async active-low), bus (i2c_master_arbiter_if.master).
module i2c_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int START_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  i2c_master_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESPOND
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   start_cnt_q;
  logic               nostart_q;

  logic [NUM_REQ-1:0] req_ack_q;
  logic [NUM_REQ-1:0] rsp_done_q;
  logic [15:0]        rsp_data_q;
  logic [4:0]         rsp_status_q;
  logic               rsp_nostart_q;
  logic [6:0]         m_chip_addr_q;
  logic [7:0]         m_reg_addr_q;
  logic [15:0]        m_datai_q;
  logic               m_we_q;
  logic               m_re_q;

  // Round-robin search: first pending index strictly after last_grant, wrapping.
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;

  always_comb begin : rr_search
    int               idx;
    logic [IDX_W-1:0] sel;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDX_W'(idx);
      if (!grant_vld && bus.req_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      start_cnt_q   <= '0;
      nostart_q     <= 1'b0;
      req_ack_q     <= '0;
      rsp_done_q    <= '0;
      rsp_data_q    <= '0;
      rsp_status_q  <= '0;
      rsp_nostart_q <= 1'b0;
      m_chip_addr_q <= '0;
      m_reg_addr_q  <= '0;
      m_datai_q     <= '0;
      m_we_q        <= 1'b0;
      m_re_q        <= 1'b0;
    end else begin
      // both pulses are single-cycle unless re-set below
      req_ack_q  <= '0;
      rsp_done_q <= '0;
      case (state_q)
        IDLE: begin
          // a master still busy from before a reset must finish first
          if (grant_vld && !bus.m_busy) begin
            m_chip_addr_q        <= bus.req_chip_addr[7*int'(grant_idx) +: 7];
            m_reg_addr_q         <= bus.req_reg_addr[8*int'(grant_idx) +: 8];
            m_datai_q            <= bus.req_data[16*int'(grant_idx) +: 16];
            m_we_q               <= bus.req_we[grant_idx];
            m_re_q               <= !bus.req_we[grant_idx];
            req_ack_q[grant_idx] <= 1'b1;
            owner_q              <= grant_idx;
            last_grant_q         <= grant_idx;
            state_q              <= ISSUE;
          end
        end
        ISSUE: begin
          m_we_q      <= 1'b0;
          m_re_q      <= 1'b0;
          start_cnt_q <= '0;
          state_q     <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.m_busy) begin
            state_q <= WAIT_DONE;
          end else begin
            start_cnt_q <= start_cnt_q + 1'b1;
            if (start_cnt_q == CNT_W'(START_WAIT - 1)) begin
              nostart_q <= 1'b1;
              state_q   <= RESPOND;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus.m_busy) state_q <= RESPOND;
        end
        RESPOND: begin
          rsp_data_q          <= bus.m_datao;
          rsp_status_q        <= bus.m_status;
          rsp_nostart_q       <= nostart_q;
          rsp_done_q[owner_q] <= 1'b1;
          nostart_q           <= 1'b0;
          state_q             <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.rsp_done    = rsp_done_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_nostart = rsp_nostart_q;
  assign bus.m_chip_addr = m_chip_addr_q;
  assign bus.m_reg_addr  = m_reg_addr_q;
  assign bus.m_datai     = m_datai_q;
  assign bus.m_we        = m_we_q;
  assign bus.m_re        = m_re_q;

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and sequencer that shares one `i2c_master` command port among `NUM_REQ` independent requesters (for example a host register bridge, a boot-time config loader and a sensor poller). It latches one requester's register read/write command and issues it to the master with a single-cycle `we`/`re` strobe. It tracks the master's `busy` until the transaction completes, then returns `datao` and `status` to the owning requester with a one-cycle completion pulse. Only one I2C transaction is in flight at a time.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `START_WAIT`, default 4: cycles to wait for `m_busy` to rise after the strobe before declaring no-start.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester command pending; must be held until that requester's `req_ack`.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_chip_addr`  in  7*NUM_REQ  7-bit chip address for requester i, at bits [7i+6:7i].
- `req_reg_addr`  in  8*NUM_REQ  register address for requester i.
- `req_data`  in  16*NUM_REQ  write data for requester i; ignored on reads.
- `req_ack`  out  NUM_REQ  one-cycle pulse: command accepted and latched.
- `rsp_done`  out  NUM_REQ  one-cycle pulse to the owner: transaction finished.
- `rsp_data`  out  16  read data; valid while `rsp_done` is nonzero, held afterwards.
- `rsp_status`  out  5  captured `m_status`.
- `rsp_nostart`  out  1  captured flag: `m_busy` never rose.
- `m_chip_addr`  out  7  to master `chip_addr`.
- `m_reg_addr`  out  8  to master `reg_addr`.
- `m_datai`  out  16  to master `datai`.
- `m_we`  out  1  to master `we`.
- `m_re`  out  1  to master `re`.
- `m_busy`  in  1  from master `busy`.
- `m_status`  in  5  from master `status`.
- `m_datao`  in  16  from master `datao`.

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESPOND.
- **IDLE:** when `|req_valid` and `!m_busy`, grant by round robin. The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - Latch the winner's fields into `m_chip_addr`, `m_reg_addr` and `m_datai`.
  - Set `m_we = req_we[g]` and `m_re = !req_we[g]`, and pulse `req_ack[g]`.
  - Store `g` in `owner` and `last_grant`, then go to ISSUE.
- **ISSUE:** one cycle with the strobe high. Clear `m_we`/`m_re`, clear `start_cnt`, go to WAIT_START.
- **WAIT_START:**
  - If `m_busy` is seen, go to WAIT_DONE.
  - Otherwise increment `start_cnt`. When `start_cnt == START_WAIT-1` with `m_busy` still low, set `nostart = 1` and go to RESPOND.
- **WAIT_DONE:** when `m_busy == 0`, go to RESPOND.
- **RESPOND:**
  - Register `rsp_data <= m_datao`, `rsp_status <= m_status`, `rsp_nostart <= nostart`, and `rsp_done[owner] <= 1` for exactly one cycle.
  - Clear `nostart`, then go to IDLE.
- `m_chip_addr`, `m_reg_addr` and `m_datai` stay stable from ISSUE through RESPOND.
- A request arriving while not in IDLE waits. `req_valid` dropping before `req_ack` withdraws the request, with no side effects.
- Exactly one bit of `req_ack` and of `rsp_done` can be set at any time.

## Timing
- Every output is registered.
- Reset values:
  - `req_ack`, `rsp_done`, `m_we`, `m_re`, `rsp_nostart` = 0.
  - `rsp_data`, `rsp_status`, `m_chip_addr`, `m_reg_addr`, `m_datai` = 0.
  - State = IDLE, `last_grant = NUM_REQ-1` (requester 0 has first priority), counters = 0.
- Cycle sequence for a grant decided at edge E0:
  - `req_ack` and `m_we`/`m_re` are high during E0..E1, for exactly one cycle.
  - WAIT_START is entered at E1.
  - `rsp_done` is asserted the cycle after `m_busy` is sampled low in WAIT_DONE.
- `rsp_done` to the next possible `req_ack`: 1 cycle, because RESPOND goes to IDLE.
- No-start path: `rsp_done` arrives `START_WAIT + 2` cycles after `req_ack`.
- Reset mid-transaction returns everything to reset values immediately. The master is not aborted. The next grant waits for `m_busy` low.
- Simultaneous requests: the winner is the first index at or after `last_grant+1`. Losers keep `req_valid` high and are served in wrap order.

## Test plan
- **Single write:** req0 writes chip 0x70, reg 0x55, data 0xAAC3.
  - One `req_ack[0]` pulse and a one-cycle `m_we`.
  - The slave stores 0xAAC3 at reg 0x55.
  - `rsp_done[0]` fires once, `rsp_nostart = 0`.
- **Read-back:** req1 reads reg 0x55 after the write. `rsp_done[1]` fires with `rsp_data = 0xAAC3`, and `m_re` is a single cycle.
- **Contention after reset:** req0 and req2 are asserted in the same cycle.
  - req0 is served first and req2 second.
  - `m_busy` is observed low between the two strobes.
  - Each requester gets exactly one ack and one done.
- **Fairness:** all four requesters hold valid for 8 transactions. The grant order is 0,1,2,3,0,1,2,3, and no ack is issued while `m_busy = 1`.
- **No-start:** with `m_busy` forced to 0, req3 reads. `rsp_done[3]` fires with `rsp_nostart = 1` exactly `START_WAIT + 2` cycles after `req_ack[3]`.
- **Reset mid-operation:** `reset_n` is pulsed low during WAIT_DONE.
  - All outputs are 0 while reset is asserted.
  - After release, a pending req1 is acked only once `m_busy = 0`, and no stale `rsp_done` appears.
